// File: rtl/axis_traffic_gen_pkg.sv
// Shared types and sizing helpers for the AXI-Stream traffic generator.
package axis_traffic_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        THROTTLE,
        DONE
    } gen_state_t;

    // Width of a counter that spans 0..cycles-1, never narrower than one bit.
    function automatic int win_cnt_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/axis_traffic_gen_if.sv
// AXI-Stream data/valid/ready/last bundle between the generator and its sink.
interface axis_traffic_gen_if #(
    parameter int DATA_WIDTH = 256
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/axis_traffic_gen_window_timer.sv
// Free-running window counter: 0..WINDOW_CYCLES-1 while run is high, cleared by start.
// Latency: wrap is combinational off the registered count, high on the last cycle of a window.
// Backpressure: none; counts every enabled cycle regardless of the stream.
module axis_traffic_gen_window_timer
    import axis_traffic_gen_pkg::*;
#(
    parameter int WINDOW_CYCLES = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic run,
    output logic wrap
);
    localparam int CNT_W = win_cnt_w(WINDOW_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign wrap = run && !start && (count == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (run) begin
            count <= (count == CNT_LAST) ? '0 : count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/axis_traffic_gen.sv
// AXI-Stream source emitting an incrementing count, throttled to a beat quota per window.
// Latency: first beat offered the cycle after enable is sampled high; back-to-back within quota.
// Backpressure: an offered beat holds data/valid until ready; stalls consume the window's quota time.
module axis_traffic_gen
    import axis_traffic_gen_pkg::*;
#(
    parameter int DATA_WIDTH    = 256,
    parameter int COUNTER_WIDTH = 32,
    parameter int WINDOW_CYCLES = 200
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [COUNTER_WIDTH-1:0] beats_per_window,
    input  logic [COUNTER_WIDTH-1:0] total_beats,
    axis_traffic_gen_if.master       axis,
    output logic                     busy,
    output logic                     done,
    output logic [COUNTER_WIDTH-1:0] sent_count
);
    localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

    gen_state_t               state, state_nxt;
    logic [COUNTER_WIDTH-1:0] quota, quota_nxt;
    logic [COUNTER_WIDTH-1:0] total, total_nxt;
    logic [COUNTER_WIDTH-1:0] seq, seq_nxt;
    logic [COUNTER_WIDTH-1:0] win_beats, win_beats_nxt;
    logic [COUNTER_WIDTH-1:0] sent_nxt;
    logic                     valid_nxt;
    logic                     last_nxt;
    logic                     accept;
    logic                     final_beat;
    logic                     win_start;
    logic                     win_run;
    logic                     wrap;

    assign accept     = axis.valid && axis.ready;
    assign final_beat = accept && (total != '0) && (sent_count + ONE == total);
    assign win_start  = (state == IDLE) && enable;
    assign win_run    = (state == SEND) || (state == THROTTLE);

    axis_traffic_gen_window_timer #(
        .WINDOW_CYCLES (WINDOW_CYCLES)
    ) u_window_timer (
        .clk   (clk),
        .reset (reset),
        .start (win_start),
        .run   (win_run),
        .wrap  (wrap)
    );

    always_comb begin
        state_nxt     = state;
        quota_nxt     = quota;
        total_nxt     = total;
        seq_nxt       = seq;
        win_beats_nxt = win_beats;
        sent_nxt      = sent_count;
        valid_nxt     = axis.valid;

        unique case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (enable) begin
                    quota_nxt     = beats_per_window;
                    total_nxt     = total_beats;
                    seq_nxt       = '0;
                    sent_nxt      = '0;
                    win_beats_nxt = '0;
                    valid_nxt     = (beats_per_window != '0);
                    state_nxt     = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    seq_nxt       = seq + ONE;
                    sent_nxt      = sent_count + ONE;
                    win_beats_nxt = win_beats + ONE;
                end
                // A beat taken on the wrap cycle belongs to the closing window.
                if (wrap) begin
                    win_beats_nxt = '0;
                end
                if (final_beat) begin
                    valid_nxt = 1'b0;
                    state_nxt = DONE;
                end else if (!enable && (accept || !axis.valid)) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end else if (accept && !wrap && (win_beats + ONE >= quota)) begin
                    valid_nxt = 1'b0;
                    state_nxt = THROTTLE;
                end
            end
            THROTTLE: begin
                valid_nxt = 1'b0;
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (wrap) begin
                    win_beats_nxt = '0;
                    valid_nxt     = 1'b1;
                    state_nxt     = SEND;
                end
            end
            DONE: begin
                valid_nxt = 1'b0;
                if (!enable) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase

        last_nxt = valid_nxt && (total_nxt != '0) && (sent_nxt + ONE == total_nxt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            quota      <= '0;
            total      <= '0;
            seq        <= '0;
            win_beats  <= '0;
            sent_count <= '0;
            axis.data  <= '0;
            axis.valid <= 1'b0;
            axis.last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            quota      <= quota_nxt;
            total      <= total_nxt;
            seq        <= seq_nxt;
            win_beats  <= win_beats_nxt;
            sent_count <= sent_nxt;
            axis.data  <= DATA_WIDTH'(seq_nxt);
            axis.valid <= valid_nxt;
            axis.last  <= last_nxt;
            busy       <= (state_nxt == SEND) || (state_nxt == THROTTLE);
            done       <= (state_nxt == DONE);
        end
    end
endmodule

// File: doc/axis_traffic_gen.md
Name: axis_traffic_gen

Overview:
- AXI-Stream source that drives the data/valid/ready interface monitored by axi_dma_sniffer.
- Emits an incrementing-count payload at a programmable rate: N beats per fixed window of WINDOW_CYCLES clocks.
- Used as the stimulus end in sniffer bring-up and in on-chip loopback tests. Gives known bitrate = min(N, WINDOW_CYCLES) * DATA_WIDTH per window, provided the sink never stalls.

Parameters:
- DATA_WIDTH, 256, stream payload width in bits.
- COUNTER_WIDTH, 32, width of the config, count and sequence counters.
- WINDOW_CYCLES, 200, throttle window length in clocks; matches the sniffer window (1 us at 200 MHz).

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level: start and keep generating; drop to stop.
- beats_per_window  in  COUNTER_WIDTH  quota of beats per window; latched at start.
- total_beats  in  COUNTER_WIDTH  stream length; 0 = unlimited; latched at start.
- data  out  DATA_WIDTH  payload = beat sequence number, zero-extended.
- valid  out  1  AXI-S valid.
- ready  in  1  AXI-S ready from the sink.
- last  out  1  high with the final beat when total_beats != 0.
- busy  out  1  high in SEND or THROTTLE.
- done  out  1  high in DONE.
- sent_count  out  COUNTER_WIDTH  number of beats accepted since the last start.

Behaviour:
- Reset (async, immediate): state=IDLE; data=0, valid=0, last=0, busy=0, done=0, sent_count=0; internal counters = 0.
- All outputs are registered.
- A beat is accepted on a rising edge where valid && ready.
- FSM states: IDLE, SEND, THROTTLE, DONE.
- IDLE:
  - On enable=1: latch beats_per_window and total_beats; clear sent_count, seq, win_cnt and win_beats; go to SEND.
  - valid rises on that same edge when quota != 0, so it is visible the cycle after enable is first sampled high.
- SEND:
  - valid=1 with data=seq.
  - On accept: seq++, sent_count++, win_beats++.
  - If the accepted beat is the final beat (sent_count+1 == total_beats, total_beats != 0): go to DONE, valid=0.
  - Else if win_beats+1 >= quota: go to THROTTLE, valid=0.
  - Else: present the next beat on the next cycle (back-to-back, no bubble).
- THROTTLE:
  - valid=0.
  - On window wrap: win_beats=0, return to SEND, valid=1.
- win_cnt:
  - Counts 0..WINDOW_CYCLES-1 continuously in SEND and THROTTLE, wrapping to 0.
  - Restarted at start.
  - A beat accepted on the wrap cycle counts against the old window.
  - On wrap in SEND, win_beats clears (an accept on that same cycle does not carry over).
- AXI rule: once valid is high, valid and data stay stable until accepted. A window wrap, quota change or enable drop never retracts an offered beat.
- enable dropped in SEND or THROTTLE:
  - Any pending offered beat completes first (wait for ready).
  - Then go to IDLE; valid=0; sent_count holds.
- DONE: done=1, busy=0, valid=0; sent_count holds. Go to IDLE when enable=0.
- last=1 only while the final beat is offered; cleared on accept.
- Quota edge cases:
  - quota=0: stay in SEND with valid=0 forever; no beats.
  - quota >= WINDOW_CYCLES: continuous streaming; THROTTLE is never entered.
- Counter widths: seq and sent_count wrap modulo 2^COUNTER_WIDTH in unlimited mode; no error.
- Config inputs changing mid-run are ignored until the next start.

Decomposition:
- Package axis_traffic_gen_pkg:
  - gen_state_t enum {IDLE, SEND, THROTTLE, DONE}.
  - Function clog2-based WIN_CNT_W derived from WINDOW_CYCLES.
- One natural sub-module: window_timer. Holds the free-running wrap counter with start/clear and a one-cycle wrap pulse. The sniffer can reuse it for its measurement window.

Test Plan:
1. quota=200, total=1000, ready=1, enable pulse-held:
   - valid high for exactly 1000 consecutive cycles, data 0..999.
   - last only with data=999; done=1; sent_count=1000.
   - axi_dma_sniffer reports 51200 per window.
2. quota=50, total=0, ready=1, run 5 windows:
   - Exactly 50 accepts then 150 valid-low cycles per 200-cycle window.
   - sent_count=250; sniffer reads 12800.
3. Backpressure: ready=0 for 3 cycles while valid=1 at data=7:
   - data stays 7 and valid stays 1.
   - sent_count unchanged until ready=1, then 8.
   - Stalls reduce the beats in that window and do not carry quota over.
4. enable dropped while valid=1, ready=0 at seq=20:
   - valid held until ready=1; accept of 20; next cycle IDLE.
   - valid=0, busy=0, sent_count=21.
5. Async reset asserted mid-SEND between clock edges:
   - All outputs 0 immediately.
   - After release with enable=1, data restarts at 0.
6. quota=0 for 1000 cycles:
   - valid never asserted, sent_count=0, busy=1, done=0.
